// File: rtl/game_sequencer.sv
// game_sequencer: frame-level controller for the invaders top level.
// Runs on the pixel clock. During scanout it latches the first laser/alien overlap of each frame.
// At every frame boundary it commits that hit: the alien is cleared, score is bumped and
// hit_alien is held for one frame. It also owns the alien alive matrix and the game FSM.
// Optional build macro SCORE_BCD_EN: score is kept as 4-digit packed BCD instead of binary.

module game_sequencer #(
    parameter int unsigned NUM_ROWS          = 3,
    parameter int unsigned NUM_COLUMNS       = 5,
    parameter int unsigned POINTS_PER_ALIEN  = 10,
    parameter int unsigned WAVE_PAUSE_FRAMES = 60,
    localparam int unsigned NumAliens        = NUM_ROWS * NUM_COLUMNS,
    localparam int unsigned RowW             = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned ColW             = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 display_on,
    input  logic                 laser_gfx,
    input  logic                 alien_pixel,
    input  logic [RowW-1:0]      alien_row,
    input  logic [ColW-1:0]      alien_col,
    input  logic                 start,
    input  logic                 invaders_landed,
    output logic [NumAliens-1:0] alive_matrix,
    output logic                 hit_alien,
    output logic [15:0]          score,
    output logic [7:0]           wave,
    output logic [1:0]           game_state,
    output logic                 play_enable
);

    localparam int unsigned IdxW = (NumAliens > 1) ? $clog2(NumAliens) : 1;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StPlay      = 2'd1;
    localparam logic [1:0] StWaveClear = 2'd2;
    localparam logic [1:0] StGameOver  = 2'd3;

    // ------------------------------------------------------------------------
    // Score arithmetic
    // ------------------------------------------------------------------------
`ifdef SCORE_BCD_EN
    localparam logic [15:0] PointsBcd = {
        4'((POINTS_PER_ALIEN / 1000) % 10),
        4'((POINTS_PER_ALIEN / 100) % 10),
        4'((POINTS_PER_ALIEN / 10) % 10),
        4'(POINTS_PER_ALIEN % 10)
    };

    // Decimal add with per-digit carry; a carry out of the thousands digit pins at 9999.
    function automatic logic [15:0] score_add(input logic [15:0] a);
        logic [4:0]  digit;
        logic        carry;
        logic [15:0] res;
        carry = 1'b0;
        res   = '0;
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, a[4*i +: 4]} + {1'b0, PointsBcd[4*i +: 4]} + {4'b0000, carry};
            if (digit >= 5'd10) begin
                digit = digit - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            res[4*i +: 4] = digit[3:0];
        end
        return carry ? 16'h9999 : res;
    endfunction
`else
    // Binary add that pins at the top of the 16-bit range instead of wrapping.
    function automatic logic [15:0] score_add(input logic [15:0] a);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(POINTS_PER_ALIEN);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 vsync_q;
    logic [1:0]           state_q,   state_d;
    logic [NumAliens-1:0] alive_q,   alive_d;
    logic                 hit_q,     hit_d;
    logic [15:0]          score_q,   score_d;
    logic [7:0]           wave_q,    wave_d;
    logic                 pending_q, pending_d;
    logic [IdxW-1:0]      hit_idx_q, hit_idx_d;
    logic [7:0]           pause_q,   pause_d;
    logic                 armed_q,   armed_d;

    logic                 frame_tick;
    logic                 cap_in_range;
    logic [IdxW-1:0]      cap_idx;
    logic                 cap_alive;
    logic                 capture;

    assign frame_tick = vsync & ~vsync_q;

    // Decode the alien under the beam and decide whether this pixel is a new hit for the frame.
    always_comb begin
        cap_in_range = (32'(alien_row) < NUM_ROWS) && (32'(alien_col) < NUM_COLUMNS);
        cap_idx      = IdxW'(32'(alien_row) * NUM_COLUMNS + 32'(alien_col));
        cap_alive    = cap_in_range ? alive_q[cap_idx] : 1'b0;
        // Overlaps on the tick cycle are dropped so a hit never straddles two frames.
        capture      = (state_q == StPlay) & display_on & laser_gfx & alien_pixel &
                       cap_alive & ~pending_q & ~frame_tick;
    end

    // Frame-boundary commit and game FSM; between ticks only the capture latch moves.
    always_comb begin
        state_d   = state_q;
        alive_d   = alive_q;
        hit_d     = hit_q;
        score_d   = score_q;
        wave_d    = wave_q;
        pending_d = pending_q;
        hit_idx_d = hit_idx_q;
        pause_d   = pause_q;
        armed_d   = armed_q;

        if (frame_tick) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StPlay;
                        alive_d   = '1;
                        score_d   = '0;
                        wave_d    = 8'd1;
                        hit_d     = 1'b0;
                        pending_d = 1'b0;
                    end
                end

                StPlay: begin
                    hit_d     = pending_q;
                    pending_d = 1'b0;
                    if (pending_q) begin
                        alive_d[hit_idx_q] = 1'b0;
                        score_d            = score_add(score_q);
                    end
                    // Landing wins over clearing the wave, but the same-tick hit still counts.
                    if (invaders_landed) begin
                        state_d = StGameOver;
                    end else if (alive_d == '0) begin
                        state_d = StWaveClear;
                        pause_d = 8'(WAVE_PAUSE_FRAMES);
                    end
                end

                StWaveClear: begin
                    hit_d   = 1'b0;
                    pause_d = pause_q - 8'd1;
                    if (pause_q <= 8'd1) begin
                        pause_d = 8'd0;
                        alive_d = '1;
                        wave_d  = (wave_q == 8'hFF) ? wave_q : wave_q + 8'd1;
                        state_d = StPlay;
                    end
                end

                default: begin
                    // Game over: a restart needs the button seen released at some tick first.
                    hit_d = 1'b0;
                    if (start && armed_q) begin
                        armed_d   = 1'b0;
                        state_d   = StPlay;
                        alive_d   = '1;
                        score_d   = '0;
                        wave_d    = 8'd1;
                        pending_d = 1'b0;
                    end else if (!start) begin
                        armed_d = 1'b1;
                    end
                end
            endcase
        end else if (capture) begin
            pending_d = 1'b1;
            hit_idx_d = cap_idx;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            state_q   <= StIdle;
            alive_q   <= '1;
            hit_q     <= 1'b0;
            score_q   <= '0;
            wave_q    <= '0;
            pending_q <= 1'b0;
            hit_idx_q <= '0;
            pause_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            state_q   <= state_d;
            alive_q   <= alive_d;
            hit_q     <= hit_d;
            score_q   <= score_d;
            wave_q    <= wave_d;
            pending_q <= pending_d;
            hit_idx_q <= hit_idx_d;
            pause_q   <= pause_d;
            armed_q   <= armed_d;
        end
    end

    assign alive_matrix = alive_q;
    assign hit_alien    = hit_q;
    assign score        = score_q;
    assign wave         = wave_q;
    assign game_state   = state_q;
    assign play_enable  = (state_q == StPlay);

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Frame-level game controller for the invaders top level. Runs on the pixel clock and detects laser/alien pixel overlap during scanout. At each frame boundary it commits hits: clears the struck alien, pulses hit_alien to the laser and updates score. It also owns the alien alive matrix and the IDLE/PLAY/WAVE_CLEAR/GAME_OVER state machine that gates cannon, laser and formation.

Parameters:
NUM_ROWS, 3, alien rows in formation
NUM_COLUMNS, 5, alien columns in formation
POINTS_PER_ALIEN, 10, score increment per hit (decimal value, 1..9999)
WAVE_PAUSE_FRAMES, 60, frames held in WAVE_CLEAR before refill (1..255)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
vsync  in  1  from hvsync generator; rising edge = frame_tick
display_on  in  1  active-video qualifier
laser_gfx  in  1  laser pixel at current hpos/vpos
alien_pixel  in  1  formation pixel at current hpos/vpos
alien_row  in  $clog2(NUM_ROWS)  row of alien under beam, valid with alien_pixel
alien_col  in  $clog2(NUM_COLUMNS)  column of alien under beam, valid with alien_pixel
start  in  1  start button, level
invaders_landed  in  1  formation reached cannon row, level
alive_matrix  out  NUM_ROWS*NUM_COLUMNS  bit r*NUM_COLUMNS+c = alien alive
hit_alien  out  1  high for exactly the frame following a committed hit
score  out  16  current score
wave  out  8  wave number
game_state  out  2  0 IDLE, 1 PLAY, 2 WAVE_CLEAR, 3 GAME_OVER
play_enable  out  1  game_state==PLAY

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. All state updates on posedge clk.
- Reset values: game_state IDLE, alive_matrix all ones, hit_alien 0, score 0, wave 0, pending 0, pause counter 0, start_armed 0.
- frame_tick: vsync registered into vsync_q; frame_tick = vsync & ~vsync_q. One-cycle latency from the vsync edge.
- Capture (PLAY only): on display_on & laser_gfx & alien_pixel & alive bit set & !pending & !frame_tick, latch row/col and set pending.
- First collision in a frame wins; later ones are ignored.
- Out-of-range row/col values are ignored.
- A collision coinciding with frame_tick is dropped.
- Commit, every frame_tick: hit_alien <= pending.
- If pending: clear the latched alive bit, add POINTS_PER_ALIEN to score, clear pending.
- hit_alien changes only on frame_tick, so it is stable across the whole frame for the vsync-clocked laser.
- Score saturates at 65535; it never wraps.
- IDLE: on frame_tick with start=1 -> PLAY. Load alive all ones, score 0, wave 1, clear hit_alien and pending.
- PLAY, evaluated on frame_tick after the commit:
  - invaders_landed=1 -> GAME_OVER. This has priority over wave clear; the same-tick hit still scores.
  - else if alive_matrix becomes all zero -> WAVE_CLEAR, pause counter <= WAVE_PAUSE_FRAMES.
- WAVE_CLEAR: no capture. Counter decrements per frame_tick. When it reaches 0: alive all ones, wave+1 (saturate 255), -> PLAY.
- GAME_OVER: score, wave and alive_matrix frozen; hit_alien cleared at the next frame_tick.
  - start_armed is set at a frame_tick with start=0.
  - At a frame_tick with start=1 and start_armed: clear start_armed and restart exactly as from IDLE.
  - A button held through game over therefore does not restart the game.
- Capture and commit are ignored outside PLAY; pending is cleared on any state change.
- reset mid-frame or mid-pause: all reset values apply on the next edge.

Optional Feature:
SCORE_BCD_EN defined:
- score is 4-digit packed BCD: [15:12] thousands ... [3:0] units.
- POINTS_PER_ALIEN is added as a decimal value with per-digit carry.
- Saturates at 16'h9999.
SCORE_BCD_EN undefined:
- score is plain binary, saturating at 16'hFFFF.

Test Plan:
- Reset asserted 3 cycles, then start=1 across one frame_tick -> game_state 1, alive_matrix 15'h7FFF, wave 1, score 0.
- Overlap at row 1, col 2 mid-frame -> at next frame_tick bit 7 clears, score 10, hit_alien 1 for one full frame then 0.
- Two overlaps in one frame (r0c0, then r2c4) -> only bit 0 cleared, score +10; r2c4 is still alive.
- Clear all 15 aliens -> state 2; after 60 frame_ticks alive 15'h7FFF, wave 2, state 1.
- Last alien hit on the same frame_tick as invaders_landed=1 -> score +10, state 3.
  - start held high -> stays 3.
  - start low for one tick, then high -> state 1, score 0.
- SCORE_BCD_EN with score preset to 16'h0995, one hit -> 16'h1005.
  - Binary mode at 65530, one hit -> 65535.
